seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller for the multi-digit common-anode 7-segment display driven by the counter datapath. It takes a packed hex/BCD value from the counter, latches it only at frame boundaries so the display never tears, and sequences the digit anodes. Each digit slot has a blanking gap to suppress ghosting. It replaces per-digit derived clocks with a single-clock, enable-counted scheduler.

## Interface
- NUM_DIGITS, 4: number of digits scanned, 1..8.
- SCAN_DIV, 50000: clk cycles per digit slot (blank plus drive).
- BLANK_CYC, 500: cycles per slot with all anodes off. Legal range 1 ≤ BLANK_CYC < SCAN_DIV.
- clk, in, 1: system clock; all logic on posedge.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: scan enable.
- load, in, 1: request to capture digits_in.
- digits_in, in, 4*NUM_DIGITS: nibble k is digit k; digit 0 is least significant and rightmost.
- an, out, NUM_DIGITS: anode enables, active-low, at most one low at a time.
- seg, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- frame_done, out, 1: one-cycle pulse at each frame start.

## Operation
- FSM states:
  - BLANK: an all 1, seg 7'h7F; stays for BLANK_CYC cycles.
  - DRIVE: an[idx]=0, seg=decode(shadow[idx]); stays for SCAN_DIV−BLANK_CYC cycles.
- DRIVE end → BLANK with idx=(idx+1) mod NUM_DIGITS. Crossing from NUM_DIGITS−1 to 0 is a frame boundary.
- Slot counter width is $clog2(SCAN_DIV). It clears on every state change and never exceeds SCAN_DIV−1.
- Load handling:
  - load=1 copies digits_in into pending and sets pend_v.
  - Repeated loads within a frame: last one wins.
- At the frame boundary edge:
  - If load=1 on that same edge, digits_in goes directly into shadow.
  - Else, if pend_v, pending goes into shadow.
  - pend_v clears in either case.
  - frame_done=1 for that one cycle.
- Decode covers hex 0–F (A–F shown as usual 7-seg letters). 0 → 7'h40, 1 → 7'h79, 8 → 7'h00, F → 7'h0E.
- en=0: on the next edge go to BLANK with idx=0 and counter=0. No frame_done pulse. load still captures into pending.
  - en rising: scanning restarts at digit 0, BLANK, first cycle. Pending applies at the next boundary.

## Timing
- Reset values (set on the rst edge, override everything including load):
  - an all 1, seg 7'h7F, frame_done 0.
  - state BLANK, idx 0, counter 0.
  - shadow 0, pending 0, pend_v 0.
- rst asserted mid-frame: all of the above on the next edge. Scanning resumes on the first edge with rst=0.
- All outputs are registered and change on the same edge as the FSM state. No combinational path from inputs to outputs.
- First DRIVE of digit 0 begins BLANK_CYC cycles after reset release.
- Frame period is NUM_DIGITS*SCAN_DIV cycles.
- Load-to-display latency is at most one frame plus BLANK_CYC cycles.
- The power-up frame shows zeros. No frame_done pulses for the reset-exit frame start.

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero suppression. For every digit k>0 whose shadow nibble and all higher nibbles are zero:
  - seg=7'h7F during its DRIVE; an still follows the normal sequence.
  - Digit 0 is always shown.
- SEG_LZ_BLANK_EN undefined: all digits always decoded.

## Structure
- Package seg_pkg:
  - FSM state enum (ST_BLANK, ST_DRIVE).
  - SEG_OFF = 7'h7F.
  - the 16-entry hex segment constant table.
- Sub-module seg_hex_decode: purely combinational nibble → seg using the seg_pkg table. Instantiated once, on the shadow nibble muxed by idx.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- Reset and scan order:
  - Stimulus: rst for 3 cycles, en=1, load 16'h1234 once.
  - Required: an all 1 for cycles 0–1 after release, then 4'b1110 for 6 cycles with seg 7'h40 (zeros, power-up frame), then 4'b1101.
  - Required: frame_done at cycle 32. Next frame digit 0 shows 7'h19 ("4"), digit 3 shows 7'h79 ("1").
- Tear-free load:
  - Stimulus: load 16'hABCD mid-frame, then 16'h0008 two cycles later.
  - Required: the current frame is unchanged; the next frame shows 0008 (last wins).
- Boundary collision:
  - Stimulus: pending holds 16'h1111 and load=1 with 16'h2222 on the frame-boundary edge.
  - Required: shadow=16'h2222, pend_v=0.
- Enable gating:
  - Stimulus: en=0 during digit 2 DRIVE for 5 cycles.
  - Required: an all 1 and no frame_done while disabled. After re-enable, 2 BLANK cycles, then digit 0 driven.
- Reset mid-operation:
  - Stimulus: rst=1 for one cycle during DRIVE.
  - Required: next cycle an all 1, seg 7'h7F, shadow 0. A subsequent frame displays zeros until a new load.
- SEG_LZ_BLANK_EN:
  - Stimulus: load 16'h0050.
  - Required: digits 3 and 2 have seg 7'h7F while their anode is low; digit 1 shows 7'h12 ("5"); digit 0 shows 7'h40.
  - Without the macro, digits 3 and 2 show 7'h40.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low 7-segment pattern, hex 0-F; purely combinational.
// No state, no backpressure.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Tear-free multi-digit 7-segment scanner with per-slot blanking; optional SEG_LZ_BLANK_EN suppresses leading zeros.
// Latency: all outputs registered, change with FSM state; no backpressure, load is always accepted.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [DW-1:0]         shadow, pending;
    logic                  pend_v;
    logic                  boundary;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg, drive_seg, seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        boundary  = 1'b0;
        if (!en) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = ST_DRIVE;
                        cnt_nxt   = '0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state_nxt = ST_BLANK;
                        cnt_nxt   = '0;
                        if (idx == IDX_LAST) begin
                            idx_nxt  = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        cur_nib = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) cur_nib = shadow[4*k +: 4];
        end
    end

    seg_hex_decode u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

`ifdef SEG_LZ_BLANK_EN
    // Digit k>0 is blank when it and every more-significant nibble are zero.
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run = run & (shadow[4*k +: 4] == 4'h0);
            if (k > 0) lz[k] = run;
        end
    end
    assign drive_seg = lz[idx] ? SEG_OFF : cur_seg;
`else
    assign drive_seg = cur_seg;
`endif

    // Entering or staying in DRIVE never changes idx or shadow, so decoding
    // the current idx gives the pattern for the next cycle.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        if (state_nxt == ST_DRIVE) begin
            an_nxt[idx_nxt] = 1'b0;
            seg_nxt         = drive_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            an         <= '1;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= boundary;
            if (boundary) begin
                if (load) begin
                    shadow <= digits_in;
                end else if (pend_v) begin
                    shadow <= pending;
                end
                pend_v <= 1'b0;
            end else if (load) begin
                pending <= digits_in;
                pend_v  <= 1'b1;
            end
        end
    end

endmodule
